// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: line/word types, arbiter state, and line alignment.
package pmem_arbiter_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_datbus;

   typedef enum logic [1:0] {
      arb_idle,
      arb_serve_i,
      arb_serve_d
   } lc3b_arb_state;

   localparam lc3b_word LINE_MASK = 16'hFFF0;

   function automatic lc3b_word line_align(lc3b_word addr);
      return addr & LINE_MASK;
   endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Shares the single pmem port between I-cache and D-cache line transactions.
// D has priority; a streak counter forces an I grant after MAX_DSTREAK D grants while I waits.
//
// state        | meaning
// arb_idle     | no transaction; grant decided on the next edge
// arb_serve_i  | I-cache line read owns pmem until pmem_resp
// arb_serve_d  | D-cache read or writeback owns pmem until pmem_resp
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int MAX_DSTREAK = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_read,
   input  logic [15:0]  i_address,
   output logic [127:0] i_rdata,
   output logic         i_resp,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [15:0]  d_address,
   input  logic [127:0] d_wdata,
   output logic [127:0] d_rdata,
   output logic         d_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

   lc3b_arb_state        state_q, state_d;
   logic [STREAK_W-1:0]  d_streak_q, d_streak_d;
   logic                 pmem_read_q, pmem_read_d;
   logic                 pmem_write_q, pmem_write_d;
   lc3b_word             pmem_address_q, pmem_address_d;
   lc3b_datbus           pmem_wdata_q, pmem_wdata_d;

   logic d_req;
   logic grant_d;

   assign d_req   = d_read | d_write;
   assign grant_d = d_req & (~i_read | (d_streak_q < STREAK_MAX));

   always_comb begin
      state_d        = state_q;
      d_streak_d     = d_streak_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;

      case (state_q)
         arb_idle: begin
            if (grant_d) begin
               state_d        = arb_serve_d;
               // Streak only grows while I is actually being held off; saturates at the limit.
               if (i_read && (d_streak_q != STREAK_MAX)) begin
                  d_streak_d = d_streak_q + 1'b1;
               end
               pmem_address_d = line_align(d_address);
               pmem_write_d   = d_write;
               pmem_read_d    = ~d_write;
               if (d_write) begin
                  pmem_wdata_d = d_wdata;
               end
            end else if (i_read) begin
               state_d        = arb_serve_i;
               d_streak_d     = '0;
               pmem_address_d = line_align(i_address);
               pmem_write_d   = 1'b0;
               pmem_read_d    = 1'b1;
            end
         end
         arb_serve_i, arb_serve_d: begin
            if (pmem_resp) begin
               state_d      = arb_idle;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
            end
         end
         default: begin
            state_d      = arb_idle;
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= arb_idle;
         d_streak_q     <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         d_streak_q     <= d_streak_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
      end
   end

   // Responses are combinational so the winner sees completion in the same cycle as pmem_resp.
   assign i_resp  = (state_q == arb_serve_i) & pmem_resp;
   assign d_resp  = (state_q == arb_serve_d) & pmem_resp;
   assign i_rdata = i_resp ? pmem_rdata : '0;
   assign d_rdata = d_resp ? pmem_rdata : '0;

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed vector table, hand sequences, randomized run vs model.
module tb_pmem_arbiter;

   localparam int MAXD = 4;
   localparam logic [127:0] A5   = {16{8'hA5}};
   localparam logic [127:0] DEAD = 128'hDEAD;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_read;
   logic [15:0]  i_address;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [15:0]  d_address;
   logic [127:0] d_wdata;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pmem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   typedef struct {
      logic         i_rd;
      logic [15:0]  i_a;
      logic         d_rd;
      logic         d_wr;
      logic [15:0]  d_a;
      logic [127:0] d_wd;
      logic         p_resp;
      logic [127:0] p_rd;
      logic         e_prd;
      logic         e_pwr;
      logic [15:0]  e_pa;
      logic [127:0] e_pwd;
      logic         e_ir;
      logic         e_dr;
      logic [127:0] e_ird;
      logic [127:0] e_drd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ir, logic [15:0] ia, logic dr, logic dw, logic [15:0] da,
                               logic [127:0] dwd, logic pr, logic [127:0] prd,
                               logic eprd, logic epwr, logic [15:0] epa, logic [127:0] epwd,
                               logic eir, logic edr, logic [127:0] eird, logic [127:0] edrd);
      vec_t v;
      v.i_rd = ir;  v.i_a = ia;  v.d_rd = dr;  v.d_wr = dw;  v.d_a = da;  v.d_wd = dwd;
      v.p_resp = pr; v.p_rd = prd;
      v.e_prd = eprd; v.e_pwr = epwr; v.e_pa = epa; v.e_pwd = epwd;
      v.e_ir = eir; v.e_dr = edr; v.e_ird = eird; v.e_drd = edrd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic eprd, input logic epwr,
                             input logic [15:0] epa, input logic [127:0] epwd,
                             input logic eir, input logic edr,
                             input logic [127:0] eird, input logic [127:0] edrd);
      chk({tag, ".pmem_read"},    128'(pmem_read),    128'(eprd));
      chk({tag, ".pmem_write"},   128'(pmem_write),   128'(epwr));
      chk({tag, ".pmem_address"}, 128'(pmem_address), 128'(epa));
      chk({tag, ".pmem_wdata"},   pmem_wdata,         epwd);
      chk({tag, ".i_resp"},       128'(i_resp),       128'(eir));
      chk({tag, ".d_resp"},       128'(d_resp),       128'(edr));
      chk({tag, ".i_rdata"},      i_rdata,            eird);
      chk({tag, ".d_rdata"},      d_rdata,            edrd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
   endtask

   // Reference model: who owns pmem, the latched command, and how many D grants I has waited through.
   int           m_owner;
   int           m_streak;
   logic         m_rd, m_wr;
   logic [15:0]  m_addr;
   logic [127:0] m_wd;

   task automatic model_reset();
      m_owner = 0; m_streak = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wd = '0;
   endtask

   task automatic model_edge();
      if (m_owner == 0) begin
         if ((d_read || d_write) && (!i_read || m_streak < MAXD)) begin
            m_owner = 2;
            if (i_read) m_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
            m_addr = {d_address[15:4], 4'h0};
            m_wr = d_write;
            m_rd = !d_write;
            if (d_write) m_wd = d_wdata;
         end else if (i_read) begin
            m_owner = 1;
            m_streak = 0;
            m_addr = {i_address[15:4], 4'h0};
            m_rd = 1; m_wr = 0;
         end
      end else if (pmem_resp) begin
         m_owner = 0; m_rd = 0; m_wr = 0;
      end
   endtask

   initial begin
      logic found;
      logic exp_d;
      logic i_seen, d_seen;
      int   r;

      rst_n = 1'b0;
      clear_inputs();
      repeat (3) tick();
      rst_n = 1'b1;

      // I-only fetch, stray resp in IDLE, D writeback beating I, then read+write together.
      vecs.push_back(mk(0,16'h0000,0,0,16'h0000,0,   0,0,      0,0,16'h0000,0,    0,0,0,0));
      vecs.push_back(mk(0,16'h0000,0,0,16'h0000,0,   1,A5,     0,0,16'h0000,0,    0,0,0,0));
      vecs.push_back(mk(1,16'h1234,0,0,16'h0000,0,   0,0,      0,0,16'h0000,0,    0,0,0,0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1,16'h1234,0,0,16'h0000,0,0,0,     1,0,16'h1230,0,    0,0,0,0));
      vecs.push_back(mk(1,16'h1234,0,0,16'h0000,0,   1,A5,     1,0,16'h1230,0,    1,0,A5,0));
      vecs.push_back(mk(0,16'h0000,0,0,16'h0000,0,   0,0,      0,0,16'h1230,0,    0,0,0,0));
      vecs.push_back(mk(1,16'h2000,0,1,16'h0040,DEAD,0,0,      0,0,16'h1230,0,    0,0,0,0));
      vecs.push_back(mk(1,16'h2000,0,1,16'h0040,DEAD,0,0,      0,1,16'h0040,DEAD, 0,0,0,0));
      vecs.push_back(mk(1,16'h2000,0,1,16'h0040,DEAD,1,128'h77,0,1,16'h0040,DEAD, 0,1,0,128'h77));
      vecs.push_back(mk(1,16'h2000,0,0,16'h0000,0,   0,0,      0,0,16'h0040,DEAD, 0,0,0,0));
      vecs.push_back(mk(1,16'h2000,0,0,16'h0000,0,   0,0,      1,0,16'h2000,DEAD, 0,0,0,0));
      vecs.push_back(mk(1,16'h2000,0,0,16'h0000,0,   1,128'hBEEF,1,0,16'h2000,DEAD,1,0,128'hBEEF,0));
      vecs.push_back(mk(0,16'h0000,1,1,16'h0ABC,128'h1111,0,0, 0,0,16'h2000,DEAD, 0,0,0,0));
      vecs.push_back(mk(0,16'h0000,1,1,16'h0ABC,128'h1111,0,0, 0,1,16'h0AB0,128'h1111,0,0,0,0));
      vecs.push_back(mk(0,16'h0000,1,1,16'h0ABC,128'h1111,1,128'h2222,0,1,16'h0AB0,128'h1111,0,1,0,128'h2222));
      vecs.push_back(mk(0,16'h0000,0,0,16'h0000,0,   0,0,      0,0,16'h0AB0,128'h1111,0,0,0,0));

      foreach (vecs[i]) begin
         i_read = vecs[i].i_rd; i_address = vecs[i].i_a;
         d_read = vecs[i].d_rd; d_write = vecs[i].d_wr; d_address = vecs[i].d_a; d_wdata = vecs[i].d_wd;
         pmem_resp = vecs[i].p_resp; pmem_rdata = vecs[i].p_rd;
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), vecs[i].e_prd, vecs[i].e_pwr, vecs[i].e_pa, vecs[i].e_pwd,
                    vecs[i].e_ir, vecs[i].e_dr, vecs[i].e_ird, vecs[i].e_drd);
         tick();
      end
      clear_inputs();

      // Reset during a D writeback withdraws the command at once; held request is re-granted after.
      d_write = 1'b1; d_address = 16'h5557; d_wdata = 128'h5;
      tick();
      @(negedge clk);
      chk("rst.pre_write", 128'(pmem_write), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("rst.pmem_write", 128'(pmem_write), 128'(0));
      chk("rst.pmem_read", 128'(pmem_read), 128'(0));
      chk("rst.pmem_address", 128'(pmem_address), 128'(0));
      chk("rst.pmem_wdata", pmem_wdata, 128'(0));
      pmem_resp = 1'b1;
      #1;
      chk("rst.d_resp", 128'(d_resp), 128'(0));
      chk("rst.d_rdata", d_rdata, 128'(0));
      pmem_resp = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("rst.regrant_write", 128'(pmem_write), 128'(1));
      chk("rst.regrant_addr", 128'(pmem_address), 128'(16'h5550));
      chk("rst.regrant_wdata", pmem_wdata, 128'h5);
      pmem_resp = 1'b1;
      #1;
      chk("rst.regrant_d_resp", 128'(d_resp), 128'(1));
      tick();
      clear_inputs();
      tick();

      // Starvation bound: I held, D always re-requesting -> DDDD I DDDD I.
      i_read = 1'b1; i_address = 16'h3008;
      d_write = 1'b1; d_address = 16'h4004; d_wdata = 128'hCAFE;
      for (int t = 0; t < 10; t++) begin
         exp_d = ((t % 5) != 4);
         found = 1'b0;
         for (int n = 0; n < 10 && !found; n++) begin
            tick();
            pmem_resp = 1'b0;
            @(negedge clk);
            if (pmem_read || pmem_write) found = 1'b1;
         end
         chk($sformatf("starve%0d.timeout", t), 128'(found), 128'(1));
         chk($sformatf("starve%0d.grant_d", t), 128'(pmem_write), 128'(exp_d));
         chk($sformatf("starve%0d.grant_i", t), 128'(pmem_read), 128'(!exp_d));
         pmem_resp = 1'b1;
         #1;
         chk($sformatf("starve%0d.d_resp", t), 128'(d_resp), 128'(exp_d));
         chk($sformatf("starve%0d.i_resp", t), 128'(i_resp), 128'(!exp_d));
      end
      tick();
      clear_inputs();
      tick();

      // Randomized run against the reference model.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      i_seen = 1'b0;
      d_seen = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (i_seen) begin
            i_read = 1'b0;
            i_seen = 1'b0;
         end else if (!i_read && $urandom_range(3) == 0) begin
            i_read = 1'b1;
            i_address = 16'($urandom);
         end
         if (d_seen) begin
            d_read = 1'b0; d_write = 1'b0;
            d_seen = 1'b0;
         end else if (!(d_read || d_write) && $urandom_range(2) == 0) begin
            r = $urandom_range(2);
            d_read = (r != 1);
            d_write = (r != 0);
            d_address = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (pmem_read || pmem_write) pmem_resp = ($urandom_range(3) == 0);
         else pmem_resp = ($urandom_range(7) == 0);
         @(negedge clk);
         check_outs($sformatf("rand%0d", cyc), m_rd, m_wr, m_addr, m_wd,
                    (m_owner == 1) && pmem_resp, (m_owner == 2) && pmem_resp,
                    ((m_owner == 1) && pmem_resp) ? pmem_rdata : 128'(0),
                    ((m_owner == 2) && pmem_resp) ? pmem_rdata : 128'(0));
         i_seen = i_resp;
         d_seen = d_resp;
         model_edge();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
